// File: rtl/frame_burst_writer.sv
// Packs a DW-bit pixel stream into AXI_DW-bit words, buffers them in a FWFT FIFO
// and drains the FIFO as fixed-length write bursts into a per-field frame buffer.
module frame_burst_writer #(
  parameter int DW         = 8,
  parameter int AXI_DW     = 64,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic              i_Sys_clk,
  input  logic              i_Rst_n,
  input  logic              i_Field_rst,
  input  logic [31:0]       i_Base_addr,
  input  logic              i_Image_vs,
  input  logic              i_Image_de,
  input  logic [DW-1:0]     i_Image_data,
  output logic              o_Wr_req,
  input  logic              i_Wr_ack,
  output logic [31:0]       o_Wr_addr,
  output logic [7:0]        o_Wr_len,
  output logic              o_Wr_valid,
  input  logic              i_Wr_ready,
  output logic [AXI_DW-1:0] o_Wr_data,
  output logic              o_Wr_last,
  output logic              o_Frame_done,
  output logic              o_Overflow
);

  localparam int PPW   = AXI_DW / DW;
  localparam int IDXW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int BYTES = AXI_DW / 8;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  // Packer
  logic              vs_q;
  logic [AXI_DW-1:0] pack_q, pack_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              push_q, push_d;
  logic [AXI_DW-1:0] push_data_q, push_data_d;
  logic              eof_set_q, eof_set_d;

  // FIFO
  logic [AXI_DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              ovf_q;
  logic              full, pop, do_push;

  // Burst FSM
  state_t      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  beat_q, beat_d;
  logic [31:0] base_q, base_d;
  logic [31:0] offset_q, offset_d;
  logic [31:0] new_base_q, new_base_d;
  logic        frst_pend_q, frst_pend_d;
  logic        eof_q, eof_d;
  logic        apply_frst;
  logic        frame_done;

  always_comb begin
    pack_d      = pack_q;
    idx_d       = idx_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    eof_set_d   = 1'b0;
    if (i_Field_rst) begin
      // A pixel arriving with the field reset belongs to no field and is dropped.
      pack_d = '0;
      idx_d  = '0;
    end else begin
      if (i_Image_de) begin
        pack_d[idx_q*DW +: DW] = i_Image_data;
        if (idx_q == IDXW'(PPW - 1)) begin
          push_d      = 1'b1;
          push_data_d = pack_d;
          pack_d      = '0;
          idx_d       = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      if (vs_q && !i_Image_vs) begin
        eof_set_d = 1'b1;
        if (idx_d != '0) begin
          push_d      = 1'b1;
          push_data_d = pack_d;
          pack_d      = '0;
          idx_d       = '0;
        end
      end
    end
  end

  // Write handshake: a beat transfers on a cycle where o_Wr_valid && i_Wr_ready;
  // the address phase completes on o_Wr_req && i_Wr_ack. valid never drops mid-burst.
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = (state_q == DATA) && i_Wr_ready;
  assign do_push = push_q && (!full || pop) && !apply_frst;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    beat_d      = beat_q;
    base_d      = base_q;
    offset_d    = offset_q;
    new_base_d  = new_base_q;
    frst_pend_d = frst_pend_q;
    eof_d       = eof_q;
    apply_frst  = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_Field_rst || frst_pend_q) begin
          apply_frst  = 1'b1;
          base_d      = i_Field_rst ? i_Base_addr : new_base_q;
          offset_d    = '0;
          eof_d       = 1'b0;
          frst_pend_d = 1'b0;
        end else if (count_q >= CW'(BURST_LEN)) begin
          len_d   = 8'(BURST_LEN - 1);
          state_d = REQ;
        end else if (eof_q && count_q != '0) begin
          len_d   = 8'(count_q - 1'b1);
          state_d = REQ;
        end else if (eof_q) begin
          frame_done = 1'b1;
          eof_d      = 1'b0;
        end
      end
      REQ: begin
        if (i_Wr_ack) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end
      DATA: begin
        if (i_Wr_ready) begin
          if (beat_q == len_q) begin
            offset_d = offset_q + (32'(len_q) + 32'd1) * 32'(BYTES);
            state_d  = IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (eof_set_q && !apply_frst) eof_d = 1'b1;
    // Field reset mid-burst: remember it and apply once the burst has finished.
    if (i_Field_rst && state_q != IDLE) begin
      frst_pend_d = 1'b1;
      new_base_d  = i_Base_addr;
    end
  end

  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      vs_q        <= 1'b0;
      pack_q      <= '0;
      idx_q       <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      eof_set_q   <= 1'b0;
      state_q     <= IDLE;
      len_q       <= '0;
      beat_q      <= '0;
      base_q      <= '0;
      offset_q    <= '0;
      new_base_q  <= '0;
      frst_pend_q <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      vs_q        <= i_Image_vs;
      pack_q      <= pack_d;
      idx_q       <= idx_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      eof_set_q   <= eof_set_d;
      state_q     <= state_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      offset_q    <= offset_d;
      new_base_q  <= new_base_d;
      frst_pend_q <= frst_pend_d;
      eof_q       <= eof_d;
    end
  end

  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (apply_frst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(pop);
      if (push_q && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge i_Sys_clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data_q;
  end

  assign o_Wr_req     = (state_q == REQ);
  assign o_Wr_addr    = o_Wr_req ? (base_q + offset_q) : '0;
  assign o_Wr_len     = len_q;
  assign o_Wr_valid   = (state_q == DATA);
  assign o_Wr_data    = o_Wr_valid ? mem[rd_ptr_q] : '0;
  assign o_Wr_last    = o_Wr_valid && (beat_q == len_q);
  assign o_Frame_done = frame_done;
  assign o_Overflow   = ovf_q;

endmodule

// File: doc/frame_burst_writer.md
Name: frame_burst_writer

Overview:
- Downstream consumer of the test-pattern/sensor stream generator.
- Packs the DW-bit pixel stream (vs/de/data) into AXI_DW-bit words and buffers them in an internal FIFO.
- Issues fixed-length write bursts into the frame buffer at the base address supplied per field.
- Signals frame completion and overflow to the frame-buffer controller.

Parameters:
DW, 8, pixel width in bits
AXI_DW, 64, write data word width; PPW = AXI_DW/DW pixels per word; must divide exactly
BURST_LEN, 16, words per full burst (1..256)
FIFO_DEPTH, 64, word FIFO depth; power of 2, >= 2*BURST_LEN

Ports:
i_Sys_clk  input  1  system clock
i_Rst_n  input  1  asynchronous active-low reset
i_Field_rst  input  1  one-cycle pulse at start of field; latches base address, clears packer
i_Base_addr  input  32  frame buffer byte base address, sampled on i_Field_rst
i_Image_vs  input  1  frame valid; falling edge = end of frame
i_Image_de  input  1  pixel valid
i_Image_data  input  DW  pixel data
o_Wr_req  output  1  burst address request, held until i_Wr_ack
i_Wr_ack  input  1  address accepted
o_Wr_addr  output  32  burst byte address
o_Wr_len  output  8  burst length minus 1
o_Wr_valid  output  1  write data valid
i_Wr_ready  input  1  write data ready
o_Wr_data  output  AXI_DW  write data word
o_Wr_last  output  1  last word of burst
o_Frame_done  output  1  one-cycle pulse, all frame data written
o_Overflow  output  1  sticky; FIFO full on push

Behaviour:
- Reset (async assert, sync release use): all outputs 0; FSM IDLE; FIFO empty; address offset 0; latched base 0.
- Packer: each cycle with i_Image_de=1 shifts pixel into word; first pixel of word lands in bits [DW-1:0] (little-endian). On PPW-th pixel, the word is pushed on the next cycle; packer index wraps to 0.
- End of frame: falling edge of i_Image_vs with index != 0 pushes the partial word, upper bytes zero-padded. Sets eof_pending.
- FIFO: synchronous, first-word-fall-through, count width clog2(FIFO_DEPTH)+1. A push while full drops the word and sets o_Overflow. Simultaneous push and pop when full is legal, with no overflow.
- FSM IDLE -> REQ when count >= BURST_LEN; o_Wr_len = BURST_LEN-1.
- FSM IDLE -> REQ when eof_pending and count > 0; o_Wr_len = count-1, with count captured at request time.
- REQ: o_Wr_req=1, o_Wr_addr = base + offset. i_Wr_ack -> DATA.
- DATA: o_Wr_valid=1 while the beat counter <= len; o_Wr_data is the FIFO head. Pop on valid&ready. o_Wr_last=1 on beat == len. On last handshake, offset += (len+1)*AXI_DW/8, then -> IDLE. o_Wr_valid never drops mid-burst once asserted; the FIFO is guaranteed to hold len+1 words at request.
- Frame done: in IDLE with eof_pending and count==0, pulse o_Frame_done for 1 cycle and clear eof_pending.
- i_Field_rst in IDLE:
  - latch i_Base_addr; offset=0; flush FIFO; packer index=0; clear o_Overflow, eof_pending.
- i_Field_rst in REQ/DATA:
  - current burst completes unmodified.
  - reset actions are deferred until FSM returns to IDLE; the new base is captured at the pulse.
  - packer is cleared immediately.
- i_Field_rst with simultaneous i_Image_de: reset wins; that pixel is discarded.
- Offset wraps modulo 2^32; no bounds check.
- Reset mid-burst: outputs drop immediately; no completion is attempted.

Test Plan:
- Defaults, 32x4 frame (128 pixels), base 0x1000_0000, ready=1:
  - exactly one burst, addr 0x1000_0000, len 15, 16 beats, last on beat 15.
  - word0 = 0x0706050403020100 for pixel values 0..127.
  - o_Frame_done pulse after last beat.
- 640x2 frame:
  - 10 bursts, addresses base+0x80*k for k=0..9.
  - then o_Frame_done; no overflow.
- 20 pixels then vs falls:
  - one burst len 2 (3 words).
  - word2 = 0x0000_0000_1312_1110 (pixel values 0..19); o_Frame_done follows.
- i_Wr_ready held 0 and i_Wr_ack held 0 during 640 continuous pixels:
  - o_Overflow sets at push #65.
  - stays set until next i_Field_rst, then clears.
- i_Field_rst with new base 0x2000_0000 during beat 5 of a burst:
  - burst finishes all 16 beats at the old address.
  - next burst goes to 0x2000_0000 with offset 0.
- Randomized i_Wr_ready (50%):
  - data order and addresses identical to the ready=1 run.
  - o_Wr_valid never deasserts mid-burst.
